// File: rtl/mc_ctrl_rv32.sv
// Multi-cycle control FSM for the RV32I core: R-type, I-ALU, LUI, LW, SW, BEQ/BNE, JAL.
// Decodes opcode/funct fields and drives the datapath strobes and mux selects.
// All outputs are registered from the next state and stay valid for the whole state.
module mc_ctrl_rv32 #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [3:0]  OP_ADD      = 4'b0000,
  parameter logic [3:0]  OP_SUB      = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       ZF,
  input  logic       mem_ready,
  output logic       PC_Write,
  output logic [1:0] PC_s,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       rs2_imm_s,
  output logic [1:0] w_data_s,
  output logic [3:0] ALU_OP_o,
  output logic       Mem_Read,
  output logic       Mem_Write,
  output logic       trap,
  output logic [4:0] state
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LW     = 7'b0000011;
  localparam logic [6:0] OPC_SW     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [4:0] {
    S_IDLE   = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_EXE_R  = 5'd3,
    S_WB_ALU = 5'd4,
    S_EXE_I  = 5'd5,
    S_WB_LUI = 5'd6,
    S_ADDR   = 5'd7,
    S_MEM_RD = 5'd8,
    S_WB_MEM = 5'd9,
    S_MEM_WR = 5'd10,
    S_BR_CMP = 5'd11,
    S_BR_UPD = 5'd12,
    S_JAL    = 5'd13,
    S_TRAP   = 5'd14
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait;
  logic             w_wait_hit;
  logic             w_taken;
  logic             w_unused_funct7;

  logic             r_pc_write;
  logic [1:0]       r_pc_s;
  logic             r_ir_write;
  logic             r_reg_write;
  logic             r_rs2_imm_s;
  logic [1:0]       r_w_data_s;
  logic [3:0]       r_alu_op;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_trap;

  // Only funct7[5] distinguishes operations in this ISA subset
  assign w_unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Last permitted wait cycle: a further miss means the memory has timed out
  assign w_wait_hit = (r_wait == CNT_W'(MEM_TIMEOUT - 1));

  // Branch decision from the ALU zero flag of the BR_CMP subtraction
  assign w_taken = ((funct3 == 3'b000) & ZF) | ((funct3 == 3'b001) & ~ZF);

  // Next-state decode
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPC_LUI:    w_next = S_WB_LUI;
          OPC_R:      w_next = S_EXE_R;
          OPC_I:      w_next = S_EXE_I;
          OPC_LW:     w_next = S_ADDR;
          OPC_SW:     w_next = S_ADDR;
          OPC_BRANCH: w_next = ((funct3 == 3'b000) || (funct3 == 3'b001)) ? S_BR_CMP : S_TRAP;
          OPC_JAL:    w_next = S_JAL;
          default:    w_next = S_TRAP;
        endcase
      end
      S_EXE_R:  w_next = S_WB_ALU;
      S_EXE_I:  w_next = S_WB_ALU;
      S_WB_ALU: w_next = S_FETCH;
      S_WB_LUI: w_next = S_FETCH;
      S_ADDR:   w_next = (opcode == OPC_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: w_next = mem_ready ? S_WB_MEM : (w_wait_hit ? S_TRAP : S_MEM_RD);
      S_WB_MEM: w_next = S_FETCH;
      S_MEM_WR: w_next = mem_ready ? S_FETCH : (w_wait_hit ? S_TRAP : S_MEM_WR);
      S_BR_CMP: w_next = S_BR_UPD;
      S_BR_UPD: w_next = S_FETCH;
      S_JAL:    w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, wait counter and registered outputs; selects hold unless the next state sets them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait      <= '0;
      r_pc_write  <= 1'b0;
      r_pc_s      <= 2'd0;
      r_ir_write  <= 1'b0;
      r_reg_write <= 1'b0;
      r_rs2_imm_s <= 1'b0;
      r_w_data_s  <= 2'd0;
      r_alu_op    <= 4'd0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_trap      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_pc_write  <= 1'b0;
      r_ir_write  <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_trap      <= r_trap | (w_next == S_TRAP);

      // Count only while staying in a memory state; any entry starts from zero
      if (((w_next == S_MEM_RD) || (w_next == S_MEM_WR)) && (r_state == w_next)) begin
        r_wait <= r_wait + CNT_W'(1);
      end else begin
        r_wait <= '0;
      end

      case (w_next)
        S_FETCH: begin
          r_ir_write <= 1'b1;
          r_pc_write <= 1'b1;
          r_pc_s     <= 2'd0;
        end
        S_EXE_R: begin
          r_alu_op    <= {funct7[5], funct3};
          r_rs2_imm_s <= 1'b0;
        end
        S_EXE_I: begin
          r_alu_op    <= (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
          r_rs2_imm_s <= 1'b1;
        end
        S_WB_ALU: begin
          r_reg_write <= 1'b1;
          r_w_data_s  <= 2'd0;
        end
        S_WB_LUI: begin
          r_reg_write <= 1'b1;
          r_w_data_s  <= 2'd1;
        end
        S_ADDR: begin
          r_alu_op    <= OP_ADD;
          r_rs2_imm_s <= 1'b1;
        end
        S_MEM_RD: r_mem_read  <= 1'b1;
        S_MEM_WR: r_mem_write <= 1'b1;
        S_WB_MEM: begin
          r_reg_write <= 1'b1;
          r_w_data_s  <= 2'd2;
        end
        S_BR_CMP: begin
          r_alu_op    <= OP_SUB;
          r_rs2_imm_s <= 1'b0;
        end
        S_BR_UPD: begin
          r_pc_s     <= 2'd1;
          r_pc_write <= w_taken;
        end
        S_JAL: begin
          r_reg_write <= 1'b1;
          r_w_data_s  <= 2'd3;
          r_pc_write  <= 1'b1;
          r_pc_s      <= 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign PC_Write  = r_pc_write;
  assign PC_s      = r_pc_s;
  assign IR_Write  = r_ir_write;
  assign Reg_Write = r_reg_write;
  assign rs2_imm_s = r_rs2_imm_s;
  assign w_data_s  = r_w_data_s;
  assign ALU_OP_o  = r_alu_op;
  assign Mem_Read  = r_mem_read;
  assign Mem_Write = r_mem_write;
  assign trap      = r_trap;
  assign state     = r_state;

endmodule

// File: tb/tb_mc_ctrl_rv32.sv
// Self-checking bench for mc_ctrl_rv32: table of instructions plus multi-cycle corner sequences.
module tb_mc_ctrl_rv32;

  logic       clk;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ZF;
  logic       mem_ready;
  logic       PC_Write;
  logic [1:0] PC_s;
  logic       IR_Write;
  logic       Reg_Write;
  logic       rs2_imm_s;
  logic [1:0] w_data_s;
  logic [3:0] ALU_OP_o;
  logic       Mem_Read;
  logic       Mem_Write;
  logic       trap;
  logic [4:0] state;

  int n_cmp = 0;
  int n_err = 0;

  mc_ctrl_rv32 dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .ZF        (ZF),
    .mem_ready (mem_ready),
    .PC_Write  (PC_Write),
    .PC_s      (PC_s),
    .IR_Write  (IR_Write),
    .Reg_Write (Reg_Write),
    .rs2_imm_s (rs2_imm_s),
    .w_data_s  (w_data_s),
    .ALU_OP_o  (ALU_OP_o),
    .Mem_Read  (Mem_Read),
    .Mem_Write (Mem_Write),
    .trap      (trap),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            zf;
    int              nst;
    logic [0:4][4:0] st;
    bit              exe_chk;
    logic [3:0]      alu;
    logic            rs2;
    logic            regw;
    bit              wd_chk;
    logic [1:0]      wd;
    logic            pcw;
    logic [1:0]      pcs;
    logic            memw;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7, logic zf,
                              int nst, logic [0:4][4:0] st, bit exe_chk, logic [3:0] alu,
                              logic rs2, logic regw, bit wd_chk, logic [1:0] wd,
                              logic pcw, logic [1:0] pcs, logic memw);
    vec_t v;
    v.opc = opc; v.f3 = f3; v.f7 = f7; v.zf = zf; v.nst = nst; v.st = st;
    v.exe_chk = exe_chk; v.alu = alu; v.rs2 = rs2; v.regw = regw;
    v.wd_chk = wd_chk; v.wd = wd; v.pcw = pcw; v.pcs = pcs; v.memw = memw;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " state"},     int'(state),     0);
    chk({tag, " PC_Write"},  int'(PC_Write),  0);
    chk({tag, " PC_s"},      int'(PC_s),      0);
    chk({tag, " IR_Write"},  int'(IR_Write),  0);
    chk({tag, " Reg_Write"}, int'(Reg_Write), 0);
    chk({tag, " rs2_imm_s"}, int'(rs2_imm_s), 0);
    chk({tag, " w_data_s"},  int'(w_data_s),  0);
    chk({tag, " ALU_OP_o"},  int'(ALU_OP_o),  0);
    chk({tag, " Mem_Read"},  int'(Mem_Read),  0);
    chk({tag, " Mem_Write"}, int'(Mem_Write), 0);
    chk({tag, " trap"},      int'(trap),      0);
  endtask

  // Step negedges until state matches; an expired budget is a failed comparison
  task automatic wait_state(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while ((int'(state) != target) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " reach state"}, int'(state), target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset FETCH", int'(state), 1);
    chk("post-reset trap", int'(trap), 0);
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    opcode = opc;
    funct3 = f3;
    funct7 = f7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0; ZF = 1'b0; mem_ready = 1'b0;

    //                opc          f3      f7           zf  n  states                         exe alu    rs2 rw wdc wd  pcw pcs memw
    vecs[0]  = mk(7'b0010011, 3'b000, 7'b0000000, 0, 4, {5'd1,5'd2,5'd5,5'd4,5'd0},  1, 4'h0, 1, 1, 1, 0, 0, 0, 0); // ADDI
    vecs[1]  = mk(7'b0110011, 3'b000, 7'b0000000, 0, 4, {5'd1,5'd2,5'd3,5'd4,5'd0},  1, 4'h0, 0, 1, 1, 0, 0, 0, 0); // ADD
    vecs[2]  = mk(7'b0110011, 3'b000, 7'b0100000, 0, 4, {5'd1,5'd2,5'd3,5'd4,5'd0},  1, 4'h8, 0, 1, 1, 0, 0, 0, 0); // SUB
    vecs[3]  = mk(7'b0010011, 3'b101, 7'b0100000, 0, 4, {5'd1,5'd2,5'd5,5'd4,5'd0},  1, 4'hD, 1, 1, 1, 0, 0, 0, 0); // SRAI
    vecs[4]  = mk(7'b0010011, 3'b100, 7'b0100000, 0, 4, {5'd1,5'd2,5'd5,5'd4,5'd0},  1, 4'h4, 1, 1, 1, 0, 0, 0, 0); // XORI, funct7 ignored
    vecs[5]  = mk(7'b0110111, 3'b000, 7'b0000000, 0, 3, {5'd1,5'd2,5'd6,5'd0,5'd0},  0, 4'h0, 0, 1, 1, 1, 0, 0, 0); // LUI
    vecs[6]  = mk(7'b0000011, 3'b010, 7'b0000000, 0, 5, {5'd1,5'd2,5'd7,5'd8,5'd9},  1, 4'h0, 1, 1, 1, 2, 0, 0, 0); // LW, zero wait
    vecs[7]  = mk(7'b0100011, 3'b010, 7'b0000000, 0, 4, {5'd1,5'd2,5'd7,5'd10,5'd0}, 1, 4'h0, 1, 0, 0, 0, 0, 0, 1); // SW, zero wait
    vecs[8]  = mk(7'b1100011, 3'b000, 7'b0000000, 1, 4, {5'd1,5'd2,5'd11,5'd12,5'd0},1, 4'h8, 0, 0, 0, 0, 1, 1, 0); // BEQ taken
    vecs[9]  = mk(7'b1100011, 3'b000, 7'b0000000, 0, 4, {5'd1,5'd2,5'd11,5'd12,5'd0},1, 4'h8, 0, 0, 0, 0, 0, 1, 0); // BEQ not taken
    vecs[10] = mk(7'b1100011, 3'b001, 7'b0000000, 1, 4, {5'd1,5'd2,5'd11,5'd12,5'd0},1, 4'h8, 0, 0, 0, 0, 0, 1, 0); // BNE not taken
    vecs[11] = mk(7'b1100011, 3'b001, 7'b0000000, 0, 4, {5'd1,5'd2,5'd11,5'd12,5'd0},1, 4'h8, 0, 0, 0, 0, 1, 1, 0); // BNE taken
    vecs[12] = mk(7'b1101111, 3'b000, 7'b0000000, 0, 3, {5'd1,5'd2,5'd13,5'd0,5'd0}, 0, 4'h0, 0, 1, 1, 3, 1, 2, 0); // JAL

    // Reset state, then IDLE -> FETCH after release
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    #1;
    chk("release IDLE", int'(state), 0);
    @(negedge clk);
    chk("first FETCH state", int'(state), 1);
    chk("first FETCH PC_Write", int'(PC_Write), 1);
    chk("first FETCH IR_Write", int'(IR_Write), 1);

    // Table-driven instructions, each starting and ending in FETCH
    mem_ready = 1'b1;
    for (int v = 0; v < 13; v++) begin
      set_instr(vecs[v].opc, vecs[v].f3, vecs[v].f7);
      ZF = vecs[v].zf;
      for (int i = 0; i < vecs[v].nst; i++) begin
        chk($sformatf("v%0d cyc%0d state", v, i), int'(state), int'(vecs[v].st[i]));
        if (i == 0) begin
          chk($sformatf("v%0d FETCH IR_Write", v), int'(IR_Write), 1);
          chk($sformatf("v%0d FETCH PC_Write", v), int'(PC_Write), 1);
          chk($sformatf("v%0d FETCH PC_s", v), int'(PC_s), 0);
        end
        if ((i == 2) && vecs[v].exe_chk) begin
          chk($sformatf("v%0d ALU_OP_o", v), int'(ALU_OP_o), int'(vecs[v].alu));
          chk($sformatf("v%0d rs2_imm_s", v), int'(rs2_imm_s), int'(vecs[v].rs2));
        end
        if (i == vecs[v].nst - 1) begin
          chk($sformatf("v%0d Reg_Write", v), int'(Reg_Write), int'(vecs[v].regw));
          if (vecs[v].wd_chk) chk($sformatf("v%0d w_data_s", v), int'(w_data_s), int'(vecs[v].wd));
          chk($sformatf("v%0d PC_Write", v), int'(PC_Write), int'(vecs[v].pcw));
          chk($sformatf("v%0d PC_s", v), int'(PC_s), int'(vecs[v].pcs));
          chk($sformatf("v%0d Mem_Write", v), int'(Mem_Write), int'(vecs[v].memw));
        end
        @(negedge clk);
      end
      chk($sformatf("v%0d back to FETCH", v), int'(state), 1);
    end

    // LW with mem_ready low for 3 cycles: Mem_Read held for 4 cycles
    mem_ready = 1'b0;
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    wait_state(8, 10, "lw-wait MEM_RD");
    cnt = 0;
    for (int k = 0; (k < 20) && (state == 5'd8); k++) begin
      cnt++;
      chk("lw-wait Mem_Read", int'(Mem_Read), 1);
      if (cnt == 4) mem_ready = 1'b1;
      @(negedge clk);
    end
    chk("lw-wait MEM_RD cycles", cnt, 4);
    chk("lw-wait WB_MEM state", int'(state), 9);
    chk("lw-wait Reg_Write", int'(Reg_Write), 1);
    chk("lw-wait w_data_s", int'(w_data_s), 2);
    chk("lw-wait Mem_Read drop", int'(Mem_Read), 0);
    @(negedge clk);
    chk("lw-wait back to FETCH", int'(state), 1);

    // Illegal opcode traps and stays trapped
    set_instr(7'b1111111, 3'b000, 7'b0000000);
    repeat (2) @(negedge clk);
    chk("illegal TRAP state", int'(state), 14);
    chk("illegal trap", int'(trap), 1);
    repeat (5) @(negedge clk);
    chk("illegal TRAP held", int'(state), 14);
    chk("illegal trap held", int'(trap), 1);
    chk("illegal PC_Write", int'(PC_Write), 0);
    chk("illegal Reg_Write", int'(Reg_Write), 0);
    do_reset();

    // Branch with funct3 outside {000,001} traps
    set_instr(7'b1100011, 3'b010, 7'b0000000);
    repeat (2) @(negedge clk);
    chk("bad-branch TRAP state", int'(state), 14);
    chk("bad-branch trap", int'(trap), 1);
    do_reset();

    // SW with mem_ready stuck low: 15 MEM_WR cycles, then TRAP
    mem_ready = 1'b0;
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    wait_state(10, 10, "sw-timeout MEM_WR");
    cnt = 0;
    for (int k = 0; (k < 40) && (state == 5'd10); k++) begin
      cnt++;
      @(negedge clk);
    end
    chk("sw-timeout MEM_WR cycles", cnt, 15);
    chk("sw-timeout TRAP state", int'(state), 14);
    chk("sw-timeout trap", int'(trap), 1);
    chk("sw-timeout Mem_Write drop", int'(Mem_Write), 0);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("sw-timeout trap sticky", int'(trap), 1);
    do_reset();

    // Reset asserted in the middle of MEM_RD drops everything at once
    mem_ready = 1'b0;
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    wait_state(8, 10, "midrst MEM_RD");
    @(negedge clk);
    chk("midrst Mem_Read before", int'(Mem_Read), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst IDLE", int'(state), 0);
    @(negedge clk);
    chk("midrst FETCH", int'(state), 1);
    chk("midrst PC_Write", int'(PC_Write), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
